f_d_reg: RTL

- IF/ID pipeline register; sits directly downstream of the fetch-stage PC register and instruction memory, feeds decode.
- Captures fetched PC, instruction, PC+8 link value and branch-delay-slot flag.
- Detects fetch address exceptions (AdEL) and carries the exception code into D.
- Supports stall (hold), flush (bubble with EPC info kept), exception/eret request clear, and a saturating stall-cycle counter for debug.

---
 rtl/f_d_reg_pkg.sv | 35 +++
 rtl/f_d_reg_fetch_exc_check.sv | 20 ++
 rtl/f_d_reg.sv | 89 ++++++++
 3 files changed

// File: rtl/f_d_reg_pkg.sv
// Shared constants and types for the fetch/decode boundary: CP0 exception codes,
// instruction-memory address window and the D-stage payload record.
package f_d_reg_pkg;

   localparam logic [4:0] EXC_NONE    = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] IM_BASE    = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFC;

   localparam logic [7:0] STALL_CNT_MAX = 8'hFF;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc8;
      logic [4:0]  exc_code;
      logic        bd;
      logic        valid;
   } d_stage_t;

   // Word-aligned and inside [base, limit] inclusive.
   function automatic logic addr_bad(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] limit);
      return (addr[1:0] != 2'b00) || (addr < base) || (addr > limit);
   endfunction

endpackage

// File: rtl/f_d_reg_fetch_exc_check.sv
// Combinational fetch-address check: flags misaligned or out-of-window PCs.
// Shared with the data-side address check by overriding the window and code.
module fetch_exc_check
   import f_d_reg_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE  = f_d_reg_pkg::IM_BASE,
   parameter logic [31:0] ADDR_LIMIT = f_d_reg_pkg::IM_LIMIT,
   parameter logic [4:0]  EXC_CODE   = f_d_reg_pkg::EXC_ADEL
) (
   input  logic [31:0] F_PC,
   output logic [4:0]  ExcCode
);

   always_comb begin
      ExcCode = EXC_NONE;
      if (addr_bad(F_PC, ADDR_BASE, ADDR_LIMIT))
         ExcCode = EXC_CODE;
   end

endmodule

// File: rtl/f_d_reg.sv
// IF/ID pipeline register: captures PC, instruction, link value and delay-slot flag,
// tags bad fetch addresses with AdEL, and counts consecutive stall cycles.
module f_d_reg
   import f_d_reg_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = f_d_reg_pkg::PC_RESET,
   parameter logic [31:0] HANDLER_PC = f_d_reg_pkg::HANDLER_PC,
   parameter logic [31:0] IM_BASE    = f_d_reg_pkg::IM_BASE,
   parameter logic [31:0] IM_LIMIT   = f_d_reg_pkg::IM_LIMIT,
   parameter logic [4:0]  EXC_ADEL   = f_d_reg_pkg::EXC_ADEL
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        F_D_Enable,
   input  logic        F_D_Flush,
   input  logic        Req,
   input  logic [31:0] F_PC,
   input  logic [31:0] F_Instr,
   input  logic        F_BD,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic [31:0] D_PC8,
   output logic [4:0]  D_ExcCode,
   output logic        D_BD,
   output logic        D_Valid,
   output logic [7:0]  D_StallCnt
);

   d_stage_t   d_q;
   logic [7:0] stall_cnt_q;
   logic [4:0] f_exc_code;

   fetch_exc_check #(
      .ADDR_BASE  (IM_BASE),
      .ADDR_LIMIT (IM_LIMIT),
      .EXC_CODE   (EXC_ADEL)
   ) u_fetch_exc_check (
      .F_PC    (F_PC),
      .ExcCode (f_exc_code)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         d_q.pc       <= PC_RESET;
         d_q.pc8      <= PC_RESET + 32'd8;
         d_q.instr    <= 32'd0;
         d_q.exc_code <= EXC_NONE;
         d_q.bd       <= 1'b0;
         d_q.valid    <= 1'b0;
         stall_cnt_q  <= 8'd0;
      end else if (Req) begin
         d_q.pc       <= HANDLER_PC;
         d_q.pc8      <= HANDLER_PC + 32'd8;
         d_q.instr    <= 32'd0;
         d_q.exc_code <= EXC_NONE;
         d_q.bd       <= 1'b0;
         d_q.valid    <= 1'b0;
         stall_cnt_q  <= 8'd0;
      end else if (F_D_Flush) begin
         // Bubble keeps PC/BD so an exception raised against it still reports a correct EPC.
         d_q.pc       <= F_PC;
         d_q.pc8      <= F_PC + 32'd8;
         d_q.instr    <= 32'd0;
         d_q.exc_code <= EXC_NONE;
         d_q.bd       <= F_BD;
         d_q.valid    <= 1'b0;
         stall_cnt_q  <= 8'd0;
      end else if (F_D_Enable) begin
         d_q.pc       <= F_PC;
         d_q.pc8      <= F_PC + 32'd8;
         d_q.instr    <= (f_exc_code != EXC_NONE) ? 32'd0 : F_Instr;
         d_q.exc_code <= f_exc_code;
         d_q.bd       <= F_BD;
         d_q.valid    <= 1'b1;
         stall_cnt_q  <= 8'd0;
      end else if (stall_cnt_q != STALL_CNT_MAX) begin
         stall_cnt_q  <= stall_cnt_q + 8'd1;
      end
   end

   assign D_PC       = d_q.pc;
   assign D_Instr    = d_q.instr;
   assign D_PC8      = d_q.pc8;
   assign D_ExcCode  = d_q.exc_code;
   assign D_BD       = d_q.bd;
   assign D_Valid    = d_q.valid;
   assign D_StallCnt = stall_cnt_q;

endmodule
